// File: rtl/inert_spi_responder_if.sv
// Pin bundle between the robot's SPI master and the inertial-sensor responder.
// Signals:
//   SS_n  slave select, active low (master -> responder)
//   SCLK  SPI clock, idles high      (master -> responder)
//   MOSI  data from master           (master -> responder)
//   MISO  data to master             (responder -> master)
//   INT   unread yaw sample pending  (responder -> master)
interface inert_spi_responder_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic INT;

    modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/inert_spi_responder.sv
// SPI slave that emulates the 6-axis inertial sensor seen by the robot's SPI
// master. It decodes 16-bit read/write frames, holds a small register file,
// and snapshots a yaw-rate source once per INT_PERIOD clocks, flagging each
// new sample on INT.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   spi        SS_n/SCLK/MOSI in, MISO/INT out (all SPI inputs async to clk)
//   yaw_rt_in  signed yaw rate source, sampled at each INT period
//   int_en     high when the configuration enables sample generation
module inert_spi_responder #(
    parameter logic [15:0] INT_PERIOD = 16'd2048,
    parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
    input  logic                        clk,
    input  logic                        rst_n,
    inert_spi_responder_if.slave        spi,
    input  logic [15:0]                 yaw_rt_in,
    output logic                        int_en
);

    localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
    localparam logic [6:0] ADDR_CTRL5     = 7'h14;
    localparam logic [6:0] ADDR_STATUS    = 7'h1E;
    localparam logic [6:0] ADDR_YAW_L     = 7'h26;
    localparam logic [6:0] ADDR_YAW_H     = 7'h27;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t      state, state_nxt;

    logic [2:0]  ss_sync, sclk_sync;
    logic [1:0]  mosi_sync;
    logic        ss_s, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    logic [3:0]  bit_cnt;
    logic [6:0]  shift_reg;
    logic [7:0]  tx;
    logic        miso_en;
    logic        rw;
    logic [6:0]  addr;

    logic [7:0]  int1_ctrl, ctrl2_g, ctrl5;
    logic [15:0] yaw_snap;
    logic        int_q, overrun, sample_pend;
    logic [15:0] period_cnt;

    logic [6:0]  cmd_addr;
    logic [7:0]  rd_data;
    logic        cmd_latch, wr_commit, read_done;
    logic        sample_evt, capture;

    // Two flops per SPI input for metastability; SS_n and SCLK get a third
    // stage so edges are detected between two settled samples. SS_n and SCLK
    // reset high (their idle level) so release of reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[0], spi.MOSI};
        end
    end

    assign ss_s      = ss_sync[1];
    assign ss_fall   = ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign mosi_s    = mosi_sync[1];

    // The address completes on the 8th rise: seven bits already shifted in
    // plus the MOSI bit arriving now.
    assign cmd_addr  = {shift_reg[5:0], mosi_s};
    assign cmd_latch = (state == CMD)  && !ss_s && sclk_rise && (bit_cnt == 4'd7);
    assign wr_commit = (state == DATA) && !ss_s && sclk_rise && (bit_cnt == 4'd15) && !rw;
    assign read_done = (state == DONE) && ss_rise && rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Any SS_n deassertion returns to IDLE; leaving CMD or DATA that way is an
    // abort, and none of the commit/clear strobes fire outside their states.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ss_fall) state_nxt = CMD;
            CMD: begin
                if (ss_s)                                   state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == 4'd7)      state_nxt = DATA;
            end
            DATA: begin
                if (ss_s)                                   state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == 4'd15)     state_nxt = DONE;
            end
            DONE: if (ss_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is selected from the address being latched, so the tx byte
    // is ready for the 9th SCLK fall.
    always_comb begin
        rd_data = 8'h00;
        case (cmd_addr)
            ADDR_INT1_CTRL: rd_data = int1_ctrl;
            ADDR_WHO_AM_I:  rd_data = WHO_AM_I;
            ADDR_CTRL2_G:   rd_data = ctrl2_g;
            ADDR_CTRL5:     rd_data = ctrl5;
            ADDR_STATUS:    rd_data = {6'b0, overrun, int_q};
            ADDR_YAW_L:     rd_data = yaw_snap[7:0];
            ADDR_YAW_H:     rd_data = yaw_snap[15:8];
            default:        rd_data = 8'h00;
        endcase
    end

    // Frame datapath. The first fall in DATA only enables MISO (tx[7] is
    // already loaded); each later fall shifts the next bit up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 4'd0;
            shift_reg <= 7'd0;
            tx        <= 8'd0;
            miso_en   <= 1'b0;
            rw        <= 1'b0;
            addr      <= 7'd0;
        end else begin
            if (state == IDLE && ss_fall) begin
                bit_cnt   <= 4'd0;
                shift_reg <= 7'd0;
                miso_en   <= 1'b0;
            end else if ((state == CMD || state == DATA) && !ss_s && sclk_rise) begin
                bit_cnt   <= bit_cnt + 4'd1;
                shift_reg <= {shift_reg[5:0], mosi_s};
            end

            if (cmd_latch) begin
                rw   <= shift_reg[6];
                addr <= cmd_addr;
                tx   <= shift_reg[6] ? rd_data : 8'h00;
            end else if (state == DATA && !ss_s && sclk_fall) begin
                if (!miso_en) miso_en <= 1'b1;
                else          tx      <= {tx[6:0], 1'b0};
            end
        end
    end

    assign spi.MISO = ((state == DATA || state == DONE) && miso_en && !ss_s) ? tx[7] : 1'b0;

    // Writable configuration registers; writes elsewhere fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1_ctrl <= 8'h00;
            ctrl2_g   <= 8'h00;
            ctrl5     <= 8'h00;
        end else if (wr_commit) begin
            case (addr)
                ADDR_INT1_CTRL: int1_ctrl <= {shift_reg, mosi_s};
                ADDR_CTRL2_G:   ctrl2_g   <= {shift_reg, mosi_s};
                ADDR_CTRL5:     ctrl5     <= {shift_reg, mosi_s};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_en <= 1'b0;
        else        int_en <= (int1_ctrl == 8'h02) && (ctrl2_g[7:4] != 4'h0);
    end

    assign sample_evt = int_en && (period_cnt == INT_PERIOD - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          period_cnt <= 16'd0;
        else if (!int_en)    period_cnt <= 16'd0;
        else if (sample_evt) period_cnt <= 16'd0;
        else                 period_cnt <= period_cnt + 16'd1;
    end

    // A sample is only taken while SS_n is high, so the snapshot never moves
    // under an active frame; an event during a frame waits in sample_pend.
    // Setting INT/overrun takes priority over the end-of-read clears.
    assign capture = (sample_evt || sample_pend) && ss_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaw_snap    <= 16'd0;
            sample_pend <= 1'b0;
            int_q       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (capture) begin
                yaw_snap    <= yaw_rt_in;
                sample_pend <= 1'b0;
            end else if (sample_evt) begin
                sample_pend <= 1'b1;
            end

            if (capture)                               int_q <= 1'b1;
            else if (read_done && addr == ADDR_YAW_H)  int_q <= 1'b0;

            if (sample_evt && int_q)                   overrun <= 1'b1;
            else if (read_done && addr == ADDR_STATUS) overrun <= 1'b0;
        end
    end

    assign spi.INT = int_q;

endmodule

// File: tb/tb_inert_spi_responder.sv
// Directed testbench for inert_spi_responder: register reads/writes, sample
// generation and INT clearing, aborts, overrun, mid-frame sampling and
// mid-frame reset. Uses a short INT period to keep runtime small.
module tb_inert_spi_responder;

    localparam int P = 1024;
    localparam int H = 5;

    logic        clk;
    logic        rst_n;
    logic [15:0] yaw_rt_in;
    logic        int_en;
    int          cyc;
    int          n_vec;
    int          n_bad;

    inert_spi_responder_if spi();

    inert_spi_responder #(
        .INT_PERIOD (16'(P)),
        .WHO_AM_I   (8'h6A)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi.slave),
        .yaw_rt_in (yaw_rt_in),
        .int_en    (int_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI transfer of up to 16 bits, mode 3 timing. Stops early (abort)
    // when nbits < 16. Returns the bits sampled on MISO at each SCLK rise and
    // the INT level just before SS_n is released.
    task automatic spi_xfer(input logic [15:0] frame, input int nbits,
                            output logic [15:0] rx, output logic int_at_end);
        rx = 16'h0000;
        spi.SS_n = 1'b0;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = frame[15-i];
            wait_clks(H);
            rx = {rx[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            wait_clks(H);
        end
        wait_clks(4);
        int_at_end = spi.INT;
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        wait_clks(8);
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        logic [15:0] rx;
        logic        ib;
        spi_xfer({1'b1, a, 8'h00}, 16, rx, ib);
        d = rx[7:0];
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] rx;
        logic        ib;
        spi_xfer({1'b0, a, d}, 16, rx, ib);
    endtask

    // Clears any pending INT, then waits for the next sample; returns the
    // cycle count at which INT was first seen high.
    task automatic sync_to_sample(output int t_evt);
        logic [7:0] d;
        int         w;
        for (int k = 0; k < 2; k++) if (spi.INT) rd(7'h27, d);
        w = 0;
        while (!spi.INT && w < 3 * P) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (spi.INT !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL sync_int_rise: got %b expected 1", spi.INT);
        end
        t_evt = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        yaw_rt_in = 16'h0000;
        wait_clks(5);
        n_vec++;
        if ({spi.MISO, spi.INT, int_en} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %b expected 000", {spi.MISO, spi.INT, int_en});
        end
        rst_n = 1'b1;
        wait_clks(5);
        n_vec++;
        if ({spi.MISO, spi.INT, int_en} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL after_reset_outputs: got %b expected 000", {spi.MISO, spi.INT, int_en});
        end
    endtask

    task automatic test_who_am_i();
        logic [15:0] rx;
        logic        ib;
        logic [7:0]  d;
        spi_xfer(16'h8F00, 16, rx, ib);
        n_vec++;
        if (rx !== 16'h006A) begin
            n_bad++;
            $display("[TB] FAIL who_am_i_frame: got %h expected 006a", rx);
        end
        rd(7'h0D, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL int1_ctrl_reset: got %h expected 00", d);
        end
        rd(7'h30, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL unmapped_read: got %h expected 00", d);
        end
        rd(7'h1E, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL status_reset: got %h expected 00", d);
        end
    endtask

    task automatic test_sample_flow();
        logic [7:0] d;
        int         w;
        yaw_rt_in = 16'hFF38;
        wr(7'h0D, 8'h02);
        n_vec++;
        if (int_en !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL int_en_partial: got %b expected 0", int_en);
        end
        wr(7'h11, 8'h60);
        n_vec++;
        if (int_en !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL int_en_set: got %b expected 1", int_en);
        end
        wr(7'h14, 8'h40);
        wr(7'h0F, 8'h55);
        wr(7'h30, 8'h99);
        rd(7'h11, d);
        n_vec++;
        if (d !== 8'h60) begin
            n_bad++;
            $display("[TB] FAIL ctrl2_g_readback: got %h expected 60", d);
        end
        rd(7'h14, d);
        n_vec++;
        if (d !== 8'h40) begin
            n_bad++;
            $display("[TB] FAIL ctrl5_readback: got %h expected 40", d);
        end
        rd(7'h0F, d);
        n_vec++;
        if (d !== 8'h6A) begin
            n_bad++;
            $display("[TB] FAIL who_am_i_ro: got %h expected 6a", d);
        end
        w = 0;
        while (!spi.INT && w < 3 * P) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (spi.INT !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL int_first_sample: got %b expected 1", spi.INT);
        end
        rd(7'h1E, d);
        n_vec++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("[TB] FAIL status_int: got %h expected 01", d);
        end
        rd(7'h26, d);
        n_vec++;
        if (d !== 8'h38) begin
            n_bad++;
            $display("[TB] FAIL yaw_low: got %h expected 38", d);
        end
        n_vec++;
        if (spi.INT !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL int_after_yaw_low: got %b expected 1", spi.INT);
        end
        rd(7'h27, d);
        n_vec++;
        if (d !== 8'hFF) begin
            n_bad++;
            $display("[TB] FAIL yaw_high: got %h expected ff", d);
        end
        n_vec++;
        if (spi.INT !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL int_clear: got %b expected 0", spi.INT);
        end
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        logic        ib;
        logic [7:0]  d;
        spi_xfer({1'b0, 7'h11, 8'hA0}, 11, rx, ib);
        rd(7'h11, d);
        n_vec++;
        if (d !== 8'h60) begin
            n_bad++;
            $display("[TB] FAIL abort_ctrl2_g: got %h expected 60", d);
        end
        n_vec++;
        if (int_en !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL abort_int_en: got %b expected 1", int_en);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int         t;
        sync_to_sample(t);
        while (cyc < t + P + 50) @(negedge clk);
        rd(7'h1E, d);
        n_vec++;
        if (d !== 8'h03) begin
            n_bad++;
            $display("[TB] FAIL status_overrun: got %h expected 03", d);
        end
        rd(7'h1E, d);
        n_vec++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("[TB] FAIL status_overrun_clear: got %h expected 01", d);
        end
        rd(7'h27, d);
        n_vec++;
        if (spi.INT !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL overrun_int_clear: got %b expected 0", spi.INT);
        end
    endtask

    task automatic test_midframe_sample();
        logic [15:0] rx;
        logic        ib;
        logic [7:0]  d;
        int          t;
        yaw_rt_in = 16'h1234;
        sync_to_sample(t);
        rd(7'h27, d);
        n_vec++;
        if (d !== 8'h12) begin
            n_bad++;
            $display("[TB] FAIL mid_old_high: got %h expected 12", d);
        end
        yaw_rt_in = 16'hABCD;
        while (cyc < t + P - 40) @(negedge clk);
        spi_xfer({1'b1, 7'h26, 8'h00}, 16, rx, ib);
        n_vec++;
        if (rx[7:0] !== 8'h34) begin
            n_bad++;
            $display("[TB] FAIL mid_stable_low: got %h expected 34", rx[7:0]);
        end
        n_vec++;
        if (ib !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL mid_int_held: got %b expected 0", ib);
        end
        n_vec++;
        if (spi.INT !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL mid_int_after: got %b expected 1", spi.INT);
        end
        rd(7'h26, d);
        n_vec++;
        if (d !== 8'hCD) begin
            n_bad++;
            $display("[TB] FAIL mid_new_low: got %h expected cd", d);
        end
        rd(7'h27, d);
        n_vec++;
        if (d !== 8'hAB) begin
            n_bad++;
            $display("[TB] FAIL mid_new_high: got %h expected ab", d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] frame;
        logic [7:0]  d;
        int          w;
        w = 0;
        while (!spi.INT && w < 2 * P) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (spi.INT !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pre_reset_int: got %b expected 1", spi.INT);
        end
        frame = 16'h8F00;
        spi.SS_n = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 10; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = frame[15-i];
            wait_clks(H);
            spi.SCLK = 1'b1;
            wait_clks(H);
        end
        n_vec++;
        if (spi.MISO !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pre_reset_miso: got %b expected 1", spi.MISO);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({spi.MISO, spi.INT, int_en} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL midframe_reset_outputs: got %b expected 000", {spi.MISO, spi.INT, int_en});
        end
        wait_clks(3);
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(5);
        rd(7'h0F, d);
        n_vec++;
        if (d !== 8'h6A) begin
            n_bad++;
            $display("[TB] FAIL post_reset_who_am_i: got %h expected 6a", d);
        end
        rd(7'h11, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL post_reset_ctrl2_g: got %h expected 00", d);
        end
    endtask

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_who_am_i();
        test_sample_flow();
        test_abort();
        test_overrun();
        test_midframe_sample();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
